mem_port_scheduler: RTL and testbench
=====================================

Name: mem_port_scheduler

Overview:
- Shares the single SDRAM controller command port between the four DMA requesters: p0 data read, p1 weight read, p2 writeback, p3 command fetch.
- Each requester hands over one transfer (start address, length in 32-bit words). The scheduler splits it into controller bursts and interleaves requesters round-robin, one burst at a time.
- Sits between the command-sequencing block, which drives the pN enables, and the SDRAM controller user port.

Parameters:
- NPORT, 4: number of requesters.
- MAX_BL, 32: maximum words per controller burst (1..64).
- FIFO_DEPTH, 64: depth in words of each port's read/write data FIFO.
- AW, 30: controller byte-address width.

Ports:
- clk  in  1  single clock; already decided.
- rst  in  1  synchronous, active-high reset; already decided.
- req_valid  in  NPORT  transfer request per port.
- req_ready  out  NPORT  port context free; a request is accepted on valid&ready.
- req_we  in  NPORT  1 = write (SDRAM←FIFO), 0 = read.
- req_addr  in  NPORT*AW  start byte address, port i at [i*AW +: AW].
- req_len  in  NPORT*16  transfer length in words.
- req_done  out  NPORT  one-cycle pulse when the last burst of a port is issued.
- rd_space  in  NPORT*7  free words in each port's read FIFO.
- wr_avail  in  NPORT*7  words held in each port's write FIFO.
- mem_cmd_en  out  1  command strobe.
- mem_cmd_instr  out  3  3'b000 write, 3'b001 read.
- mem_cmd_bl  out  6  burst length minus 1.
- mem_cmd_byte_addr  out  AW  burst start address.
- mem_cmd_full  in  1  controller command FIFO full.
- grant  out  NPORT  one-hot owner of the current/last command; steers the data mux.
- busy  out  1  any context active or FSM not in ARB.

Behaviour:
- **Reset (rst=1 at a clk edge):**
  - All contexts are cleared and FSM → ARB.
  - Outputs: req_ready=all 1s, req_done=0, mem_cmd_en=0, mem_cmd_instr=0, mem_cmd_bl=0, mem_cmd_byte_addr=0, grant=0, busy=0.
  - The round-robin pointer resets to port 0 having highest priority.
  - Reset mid-transfer drops all pending work; no partial command is issued after reset.
- **Per-port context:** active, we, addr (AW), rem (16).
  - Accept: active←1, addr←{req_addr[AW-1:2],2'b00} (low bits forced 0), rem←req_len.
  - req_ready[i] = !active[i], registered.
  - If req_len=0: no command is issued; req_done[i] pulses the cycle after acceptance and ready returns the same cycle.
- **Burst size:** bl = min(rem, MAX_BL).
- **Eligibility:**
  - read: active & rd_space ≥ bl.
  - write: active & wr_avail ≥ bl.
- **FSM:**
  - ARB:
    - Pick the first eligible port starting at (last_grant+1) mod NPORT.
    - Latch grant, instr, bl-1, addr, then → ISSUE.
    - If none is eligible, stay in ARB.
  - ISSUE:
    - mem_cmd_en=1 in the cycle mem_cmd_full=0, then → UPDATE.
    - While mem_cmd_full=1: hold the command fields stable, mem_cmd_en=0.
  - UPDATE:
    - addr += bl*4, modulo 2^AW (wraps silently).
    - rem -= bl.
    - If rem becomes 0: active←0, req_done pulse, ready←1 (all in the same cycle).
    - → ARB.
- **Throughput and latency:** minimum 3 cycles per burst (ARB, ISSUE, UPDATE). The first command comes 2 cycles after acceptance.
- **Simultaneous events:**
  - A new request on port i during port i's done cycle is not accepted, because ready was 0 at that edge; it is accepted next cycle.
  - Requests on other ports are accepted in any state.
  - The last_grant pointer updates only on an issued command.
- **Output timing:** mem_cmd_* and grant are registered; grant holds its value after the command until the next ARB selection.

Decomposition:
- Package mem_sched_pkg:
  - Instruction codes INSTR_WR=3'b000, INSTR_RD=3'b001.
  - FSM state encoding ARB/ISSUE/UPDATE.
  - Default MAX_BL and FIFO_DEPTH.
- Sub-module rr_picker:
  - Combinational rotate-priority encoder.
  - Inputs: eligible vector, last_grant one-hot.
  - Outputs: one-hot pick, any.

Test Plan:
1. p0 read, addr 0x100, len 70, rd_space=64 → three commands: (addr 0x100, bl 31), (0x180, 31), (0x200, 5), instr 001; req_done[0] pulses once, on the UPDATE cycle after the third command.
2. p0 and p1 reads, len 64 each, accepted in the same cycle → grant order p0,p1,p0,p1; 4 commands; done p0 before p1.
3. p2 write, len 32, wr_avail=20 → no command; raise wr_avail to 32 → command issued 2 cycles later, instr 000, bl 31.
4. mem_cmd_full held 1 for 5 cycles during ISSUE → mem_cmd_en stays 0 and the fields stay constant; exactly one strobe after full drops.
5. p3 read, len 0 → req_done[3] pulses the next cycle, no mem_cmd_en, req_ready[3]=1.
6. rst asserted after the first burst of a len-96 read → no further commands; req_ready=1111, busy=0; a new len-32 request issues normally.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared constants and types for the SDRAM command-port scheduler.
// Instruction codes match the controller user port; the FSM has three phases per burst.
package mem_sched_pkg;

  localparam int unsigned NPORT_DEF      = 4;
  localparam int unsigned MAX_BL_DEF     = 32;
  localparam int unsigned FIFO_DEPTH_DEF = 64;
  localparam int unsigned AW_DEF         = 30;

  localparam int unsigned LEN_W = 16;
  localparam int unsigned BL_W  = 6;

  localparam logic [2:0] INSTR_WR = 3'b000;
  localparam logic [2:0] INSTR_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_UPDATE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_port_scheduler_rr_picker.sv
// Rotating-priority picker: first eligible port after the last granted one.
// Purely combinational; last_grant is expected one-hot.
module rr_picker #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] eligible,
  input  logic [N-1:0] last_grant,
  output logic [N-1:0] pick,
  output logic         any
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] base;
  logic [IW-1:0] idx;

  always_comb begin
    base = '0;
    for (int unsigned j = 0; j < N; j++) begin
      if (last_grant[j]) base = IW'(j);
    end
    pick = '0;
    any  = 1'b0;
    idx  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IW'((32'(base) + k) % N);
      if (!any && eligible[idx]) begin
        pick[idx] = 1'b1;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the SDRAM controller command port among DMA requesters, splitting each
// transfer into bursts and interleaving ports round-robin one burst at a time.
module mem_port_scheduler
  import mem_sched_pkg::*;
#(
  parameter int unsigned NPORT      = NPORT_DEF,
  parameter int unsigned MAX_BL     = MAX_BL_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned AW         = AW_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NPORT-1:0]                        req_valid,
  output logic [NPORT-1:0]                        req_ready,
  input  logic [NPORT-1:0]                        req_we,
  input  logic [NPORT*AW-1:0]                     req_addr,
  input  logic [NPORT*LEN_W-1:0]                  req_len,
  output logic [NPORT-1:0]                        req_done,
  input  logic [NPORT*$clog2(FIFO_DEPTH+1)-1:0]   rd_space,
  input  logic [NPORT*$clog2(FIFO_DEPTH+1)-1:0]   wr_avail,
  output logic                                    mem_cmd_en,
  output logic [2:0]                              mem_cmd_instr,
  output logic [BL_W-1:0]                         mem_cmd_bl,
  output logic [AW-1:0]                           mem_cmd_byte_addr,
  input  logic                                    mem_cmd_full,
  output logic [NPORT-1:0]                        grant,
  output logic                                    busy
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

  state_e             state_q, state_d;
  logic [NPORT-1:0]   active_q, active_d;
  logic [NPORT-1:0]   we_q, we_d;
  logic [AW-1:0]      addr_q [NPORT];
  logic [AW-1:0]      addr_d [NPORT];
  logic [LEN_W-1:0]   rem_q [NPORT];
  logic [LEN_W-1:0]   rem_d [NPORT];
  logic [NPORT-1:0]   ready_q, ready_d;
  logic [NPORT-1:0]   done_q, done_d;
  logic [NPORT-1:0]   grant_q, grant_d;
  logic [NPORT-1:0]   last_q, last_d;
  logic               cmd_en_q, cmd_en_d;
  logic [2:0]         instr_q, instr_d;
  logic [BL_W-1:0]    bl_q, bl_d;
  logic [AW-1:0]      caddr_q, caddr_d;
  logic               busy_q, busy_d;

  logic [LEN_W-1:0]   bl_len [NPORT];
  logic [LW-1:0]      lvl [NPORT];
  logic [NPORT-1:0]   elig;
  logic [NPORT-1:0]   pick;
  logic               pick_any;
  logic [LEN_W-1:0]   blw;

  // Burst size and FIFO-level eligibility per port
  always_comb begin
    for (int unsigned i = 0; i < NPORT; i++) begin
      bl_len[i] = (rem_q[i] > LEN_W'(MAX_BL)) ? LEN_W'(MAX_BL) : rem_q[i];
      lvl[i]    = we_q[i] ? wr_avail[i*LW +: LW] : rd_space[i*LW +: LW];
      elig[i]   = active_q[i] && (LEN_W'(lvl[i]) >= bl_len[i]);
    end
  end

  rr_picker #(.N(NPORT)) u_pick (
    .eligible   (elig),
    .last_grant (last_q),
    .pick       (pick),
    .any        (pick_any)
  );

  assign blw = LEN_W'(bl_q) + LEN_W'(1);

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    we_d     = we_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    done_d   = '0;
    grant_d  = grant_q;
    last_d   = last_q;
    cmd_en_d = 1'b0;
    instr_d  = instr_q;
    bl_d     = bl_q;
    caddr_d  = caddr_q;

    unique case (state_q)
      ST_ARB: begin
        if (pick_any) begin
          grant_d = pick;
          for (int unsigned i = 0; i < NPORT; i++) begin
            if (pick[i]) begin
              instr_d = we_q[i] ? INSTR_WR : INSTR_RD;
              bl_d    = BL_W'(bl_len[i] - LEN_W'(1));
              caddr_d = addr_q[i];
            end
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!mem_cmd_full) begin
          cmd_en_d = 1'b1;
          last_d   = grant_q;
          state_d  = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        for (int unsigned i = 0; i < NPORT; i++) begin
          if (grant_q[i]) begin
            addr_d[i] = addr_q[i] + (AW'(blw) << 2);
            rem_d[i]  = rem_q[i] - blw;
            if (rem_q[i] == blw) begin
              active_d[i] = 1'b0;
              done_d[i]   = 1'b1;
            end
          end
        end
        state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase

    // Zero-length transfers complete immediately without ever going active
    for (int unsigned i = 0; i < NPORT; i++) begin
      if (req_valid[i] && ready_q[i]) begin
        if (req_len[i*LEN_W +: LEN_W] == '0) begin
          done_d[i] = 1'b1;
        end else begin
          active_d[i] = 1'b1;
          we_d[i]     = req_we[i];
          addr_d[i]   = {req_addr[i*AW+2 +: AW-2], 2'b00};
          rem_d[i]    = req_len[i*LEN_W +: LEN_W];
        end
      end
    end

    ready_d = ~active_d;
    busy_d  = (|active_d) || (state_d != ST_ARB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_ARB;
      active_q <= '0;
      we_q     <= '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
        addr_q[i] <= '0;
        rem_q[i]  <= '0;
      end
      ready_q  <= '1;
      done_q   <= '0;
      grant_q  <= '0;
      last_q   <= {1'b1, {(NPORT-1){1'b0}}};
      cmd_en_q <= 1'b0;
      instr_q  <= '0;
      bl_q     <= '0;
      caddr_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cmd_en_q <= cmd_en_d;
      instr_q  <= instr_d;
      bl_q     <= bl_d;
      caddr_q  <= caddr_d;
      busy_q   <= busy_d;
    end
  end

  assign req_ready         = ready_q;
  assign req_done          = done_q;
  assign mem_cmd_en        = cmd_en_q;
  assign mem_cmd_instr     = instr_q;
  assign mem_cmd_bl        = bl_q;
  assign mem_cmd_byte_addr = caddr_q;
  assign grant             = grant_q;
  assign busy              = busy_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Self-checking bench for mem_port_scheduler: directed scenarios plus random
// batches compared against a round-robin burst-list model.
module tb_mem_port_scheduler;

  localparam int NP = 4;
  localparam int AW = 30;
  localparam int LW = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_valid, req_ready, req_we, req_done, grant;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*16-1:0]  req_len;
  logic [NP*LW-1:0]  rd_space, wr_avail;
  logic              mem_cmd_en, mem_cmd_full, busy;
  logic [2:0]        mem_cmd_instr;
  logic [5:0]        mem_cmd_bl;
  logic [AW-1:0]     mem_cmd_byte_addr;

  always #5 clk = ~clk;

  mem_port_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_len           (req_len),
    .req_done          (req_done),
    .rd_space          (rd_space),
    .wr_avail          (wr_avail),
    .mem_cmd_en        (mem_cmd_en),
    .mem_cmd_instr     (mem_cmd_instr),
    .mem_cmd_bl        (mem_cmd_bl),
    .mem_cmd_byte_addr (mem_cmd_byte_addr),
    .mem_cmd_full      (mem_cmd_full),
    .grant             (grant),
    .busy              (busy)
  );

  typedef struct {
    int          port;
    logic [3:0]  gnt;
    logic [2:0]  instr;
    logic [5:0]  bl;
    logic [29:0] addr;
    int          cyc;
  } cmd_t;

  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  int   lastp = 3;
  cmd_t pend[$];
  cmd_t expq[$];
  cmd_t obsq[$];
  int   done_cnt[NP];
  int   done_cyc[NP];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input bit we, input logic [29:0] a, input int len);
    req_we[p]             = we;
    req_addr[p*AW +: AW]  = a;
    req_len[p*16 +: 16]   = 16'(len);
  endtask

  // Model: a transfer is a list of min(rem,32)-word bursts at word-aligned addresses
  function automatic void plan(input int p, input bit we, input logic [29:0] a, input int len);
    logic [29:0] ad;
    int r;
    int b;
    cmd_t c;
    ad = {a[29:2], 2'b00};
    r  = len;
    while (r > 0) begin
      b       = (r > 32) ? 32 : r;
      c.port  = p;
      c.gnt   = 4'(1 << p);
      c.instr = we ? 3'b000 : 3'b001;
      c.bl    = 6'(b - 1);
      c.addr  = ad;
      c.cyc   = 0;
      pend.push_back(c);
      ad = ad + 30'(b * 4);
      r  = r - b;
    end
  endfunction

  // Model: all ports eligible from the start, so bursts go strictly round-robin
  function automatic void order();
    bit found;
    int p;
    while (pend.size() > 0) begin
      found = 1'b0;
      for (int k = 1; k <= NP; k++) begin
        p = (lastp + k) % NP;
        if (!found) begin
          for (int i = 0; i < pend.size(); i++) begin
            if (!found && pend[i].port == p) begin
              expq.push_back(pend[i]);
              pend.delete(i);
              lastp = p;
              found = 1'b1;
            end
          end
        end
      end
    end
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NP; i++) if (v == 4'(1 << i)) r = i;
    return r;
  endfunction

  task automatic clear_done();
    for (int p = 0; p < NP; p++) begin
      done_cnt[p] = 0;
      done_cyc[p] = -1;
    end
  endtask

  task automatic drain(input int maxc, input bit rnd_full);
    int   n;
    bit   fin;
    cmd_t c;
    n   = 0;
    fin = 1'b0;
    while (!fin) begin
      if (mem_cmd_en) begin
        c.port  = onehot_idx(grant);
        c.gnt   = grant;
        c.instr = mem_cmd_instr;
        c.bl    = mem_cmd_bl;
        c.addr  = mem_cmd_byte_addr;
        c.cyc   = cyc;
        obsq.push_back(c);
      end
      for (int p = 0; p < NP; p++) begin
        if (req_done[p]) begin
          done_cnt[p]++;
          done_cyc[p] = cyc;
        end
      end
      if (!busy && !mem_cmd_en) begin
        fin = 1'b1;
      end else if (n >= maxc) begin
        chk("drain_timeout_busy", 64'(busy), 64'(0));
        fin = 1'b1;
      end else begin
        mem_cmd_full = rnd_full ? ($urandom % 4 == 0) : 1'b0;
        step();
        n++;
      end
    end
    mem_cmd_full = 1'b0;
  endtask

  task automatic compare(input string tag);
    int n;
    chk($sformatf("%s_ncmd", tag), 64'(obsq.size()), 64'(expq.size()));
    n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_cmd%0d", tag, i),
          64'({obsq[i].gnt, obsq[i].instr, obsq[i].bl, obsq[i].addr}),
          64'({expq[i].gnt, expq[i].instr, expq[i].bl, expq[i].addr}));
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_valid    = '0;
    mem_cmd_full = 1'b0;
    step();
    step();
    rst   = 1'b0;
    lastp = 3;
    pend.delete();
    expq.delete();
    obsq.delete();
    clear_done();
  endtask

  initial begin
    int acc;
    int first;
    int lastc;
    int cnt;
    int n;
    logic [3:0] v;
    bit we;
    logic [29:0] a;
    int len;

    rst          = 1'b1;
    req_valid    = '0;
    req_we       = '0;
    req_addr     = '0;
    req_len      = '0;
    mem_cmd_full = 1'b0;
    rd_space     = {NP{7'd64}};
    wr_avail     = {NP{7'd64}};

    // Reset state
    do_reset();
    chk("rst_ready", 64'(req_ready), 64'(4'b1111));
    chk("rst_done", 64'(req_done), 64'(0));
    chk("rst_en", 64'(mem_cmd_en), 64'(0));
    chk("rst_fields", 64'({mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}), 64'(0));
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));

    // 1: single read split into 32/32/6 bursts
    set_req(0, 1'b0, 30'h100, 70);
    plan(0, 1'b0, 30'h100, 70);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    acc = cyc;
    chk("t1_ready", 64'(req_ready), 64'(4'b1110));
    chk("t1_busy", 64'(busy), 64'(1));
    order();
    drain(500, 1'b0);
    first = (obsq.size() > 0) ? obsq[0].cyc : -100;
    lastc = (obsq.size() > 0) ? obsq[obsq.size()-1].cyc : -100;
    chk("t1_latency", 64'(first - acc), 64'(2));
    compare("t1");
    chk("t1_done_cnt", 64'(done_cnt[0]), 64'(1));
    chk("t1_done_cyc", 64'(done_cyc[0]), 64'(lastc + 1));
    chk("t1_ready_end", 64'(req_ready), 64'(4'b1111));

    // 2: two reads interleave p0,p1,p0,p1
    do_reset();
    set_req(0, 1'b0, 30'h1000, 64);
    set_req(1, 1'b0, 30'h2000, 64);
    plan(0, 1'b0, 30'h1000, 64);
    plan(1, 1'b0, 30'h2000, 64);
    req_valid = 4'b0011;
    step();
    req_valid = '0;
    order();
    drain(500, 1'b0);
    compare("t2");
    chk("t2_done_cnt", 64'({done_cnt[0], done_cnt[1]}), 64'({32'd1, 32'd1}));
    chk("t2_done_order", 64'(done_cyc[0] < done_cyc[1]), 64'(1));

    // 3: write held off until enough words are in the write FIFO
    do_reset();
    wr_avail = '0;
    wr_avail[2*LW +: LW] = 7'd20;
    set_req(2, 1'b1, 30'h400, 32);
    plan(2, 1'b1, 30'h400, 32);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    for (int i = 0; i < 6; i++) begin
      chk("t3_no_cmd", 64'(mem_cmd_en), 64'(0));
      step();
    end
    chk("t3_busy_wait", 64'(busy), 64'(1));
    wr_avail[2*LW +: LW] = 7'd32;
    step();
    chk("t3_en_early", 64'(mem_cmd_en), 64'(0));
    step();
    chk("t3_en", 64'(mem_cmd_en), 64'(1));
    order();
    drain(500, 1'b0);
    compare("t3");
    chk("t3_done_cnt", 64'(done_cnt[2]), 64'(1));
    wr_avail = {NP{7'd64}};

    // 4: command held stable while controller FIFO is full
    do_reset();
    mem_cmd_full = 1'b1;
    set_req(0, 1'b0, 30'h3000, 32);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t4_en_held", 64'(mem_cmd_en), 64'(0));
      chk("t4_fields_held", 64'({grant, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr}),
          64'({4'b0001, 3'b001, 6'd31, 30'h3000}));
      step();
    end
    mem_cmd_full = 1'b0;
    step();
    chk("t4_en_after", 64'(mem_cmd_en), 64'(1));
    cnt = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_cmd_en) cnt++;
    end
    chk("t4_strobes", 64'(cnt), 64'(1));
    chk("t4_idle", 64'(busy), 64'(0));

    // 5: zero-length request completes without a command
    do_reset();
    set_req(3, 1'b0, 30'h500, 0);
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    chk("t5_done", 64'(req_done), 64'(4'b1000));
    chk("t5_ready", 64'(req_ready), 64'(4'b1111));
    chk("t5_en", 64'(mem_cmd_en), 64'(0));
    step();
    chk("t5_done_clr", 64'(req_done), 64'(0));
    chk("t5_en2", 64'(mem_cmd_en), 64'(0));

    // 6: reset mid-transfer drops pending bursts
    do_reset();
    set_req(0, 1'b0, 30'h8000, 96);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    n = 0;
    while (!mem_cmd_en && n < 10) begin
      step();
      n++;
    end
    chk("t6_first_cmd", 64'(mem_cmd_en), 64'(1));
    rst = 1'b1;
    step();
    rst   = 1'b0;
    lastp = 3;
    chk("t6_ready", 64'(req_ready), 64'(4'b1111));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_grant", 64'(grant), 64'(0));
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_cmd_en) cnt++;
      step();
    end
    chk("t6_no_cmd", 64'(cnt), 64'(0));
    clear_done();
    set_req(1, 1'b0, 30'h9000, 32);
    plan(1, 1'b0, 30'h9000, 32);
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    order();
    drain(500, 1'b0);
    compare("t6_new");
    chk("t6_done_cnt", 64'(done_cnt[1]), 64'(1));

    // Random batches with stalls, wrap-around addresses and zero lengths
    for (int b = 0; b < 25; b++) begin
      expq.delete();
      obsq.delete();
      clear_done();
      v = 4'($urandom_range(1, 15));
      for (int p = 0; p < NP; p++) begin
        if (v[p]) begin
          we  = 1'($urandom % 2);
          a   = ($urandom % 4 == 0) ? (30'h3FFFFF00 | 30'($urandom % 256)) : 30'($urandom);
          len = ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 140));
          set_req(p, we, a, len);
          plan(p, we, a, len);
        end
      end
      req_valid = v;
      step();
      req_valid = '0;
      order();
      drain(3000, 1'b1);
      compare($sformatf("rnd%0d", b));
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("rnd%0d_done_p%0d", b, p), 64'(done_cnt[p]), 64'(v[p] ? 1 : 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
